alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb_pkg.sv | 22 ++
 rtl/alu_share_arb_alu_core.sv | 46 ++++
 rtl/alu_share_arb.sv | 148 ++++++++++++++
 tb/tb_alu_share_arb.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for alu_share_arb: operation codes, FSM state encoding
// and the default datapath width.
package alu_share_arb_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_NEG = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_INC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_share_arb_alu_core.sv
// Combinational ALU shared by both requesters; zero latency, no backpressure.
// Carry/borrow is reported only for add and subtract.
module alu_core #(
  parameter int DATA_W = alu_share_arb_pkg::DATA_W_DEF
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res,
  output logic              o_ovf
);
  import alu_share_arb_pkg::*;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W:0] ext_a;
  logic [DATA_W:0] ext_b;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    ext_a = {1'b0, i_a};
    ext_b = {1'b0, i_b};
    sum   = ext_a + ext_b;
    diff  = ext_a - ext_b;
    o_res = '0;
    o_ovf = 1'b0;
    case (i_op)
      OP_NEG: o_res = ~i_a + ONE;
      OP_AND: o_res = i_a & i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_DEC: o_res = i_a - ONE;
      OP_ADD: begin
        o_res = sum[DATA_W-1:0];
        o_ovf = sum[DATA_W];
      end
      OP_SUB: begin
        o_res = diff[DATA_W-1:0];
        o_ovf = diff[DATA_W];
      end
      default: o_res = i_a + ONE;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end to one shared ALU; accept -> valid 2 edges, 3 cycles/op.
// Requesters stall until IDLE; the result is held until i_rsp_ready. Option: ALU_SHARE_ARB_OVF_STICKY_EN.
module alu_share_arb #(
  parameter int DATA_W = alu_share_arb_pkg::DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req1_valid,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  input  logic [2:0]        i_req0_op,
  input  logic [2:0]        i_req1_op,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_ovf,
`ifdef ALU_SHARE_ARB_OVF_STICKY_EN
  input  logic [1:0]        i_ovf_clr,
  output logic [1:0]        o_ovf_sticky,
`endif
  output logic              o_busy
);
  import alu_share_arb_pkg::*;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              gnt_vld;
  logic              gnt_id;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .i_op  (op_q),
    .i_a   (a_q),
    .i_b   (b_q),
    .o_res (alu_res),
    .o_ovf (alu_ovf)
  );

  // ptr_q holds the last granted id; on a tie the other requester wins.
  always_comb begin
    gnt_vld = i_req0_valid | i_req1_valid;
    gnt_id  = (i_req0_valid & i_req1_valid) ? ~ptr_q : i_req1_valid;
  end

  // Gated by reset so the readies drop with the asynchronous reset as well.
  assign o_req0_ready = i_rst_n & (state_q == ST_IDLE) & gnt_vld & ~gnt_id;
  assign o_req1_ready = i_rst_n & (state_q == ST_IDLE) & gnt_vld &  gnt_id;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = id_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_ovf    = rsp_ovf_q;
  assign o_busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_EXEC;
          id_d    = gnt_id;
          op_d    = gnt_id ? i_req1_op : i_req0_op;
          a_d     = gnt_id ? i_req1_a  : i_req0_a;
          b_d     = gnt_id ? i_req1_b  : i_req0_b;
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_data_d  = alu_res;
        rsp_ovf_d   = alu_ovf;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          ptr_d       = id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

`ifdef ALU_SHARE_ARB_OVF_STICKY_EN
  logic [1:0] sticky_q, sticky_d;
  logic [1:0] sticky_set;

  // Set on the EXEC->RESP edge; a same-edge clear takes priority.
  always_comb begin
    sticky_set = 2'b00;
    if ((state_q == ST_EXEC) && alu_ovf) sticky_set[id_q] = 1'b1;
    sticky_d = (sticky_q | sticky_set) & ~i_ovf_clr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sticky_q <= 2'b00;
    else          sticky_q <= sticky_d;
  end

  assign o_ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed corner cases, then randomized traffic
// checked against a plain-arithmetic reference model.
module tb_alu_share_arb;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, rsp_rdy = 1'b0;
  logic [2:0]    op0 = '0, op1 = '0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          r0, r1, rv, rid, rovf, busy;
  logic [W-1:0]  rdata;
`ifdef ALU_SHARE_ARB_OVF_STICKY_EN
  logic [1:0]    ovf_clr = 2'b00;
  logic [1:0]    sticky;
`endif

  alu_share_arb #(.DATA_W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req1_valid(v1),
    .o_req0_ready(r0), .o_req1_ready(r1),
    .i_req0_op(op0), .i_req1_op(op1),
    .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
    .o_rsp_valid(rv), .i_rsp_ready(rsp_rdy),
    .o_rsp_id(rid), .o_rsp_data(rdata), .o_rsp_ovf(rovf),
`ifdef ALU_SHARE_ARB_OVF_STICKY_EN
    .i_ovf_clr(ovf_clr), .o_ovf_sticky(sticky),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           id;
    logic [W-1:0] data;
    bit           ovf;
    int           acc_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t rsp_log[$];
  bit   grant_log[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_acc = 0;
  bit m_free = 1'b1;
  bit m_last = 1'b1;
  bit m_last_nxt = 1'b0;
  bit m_release = 1'b0;
  bit prev_vld = 1'b0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  // Reference ALU: unsigned arithmetic in 64 bits, reduced modulo 2^W.
  function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output bit o);
    longint unsigned aa, bb, r, m;
    aa = a; bb = b; m = 64'd1 << W; o = 1'b0; r = 0;
    case (op)
      3'd0: r = m - aa;
      3'd1: r = aa & bb;
      3'd2: r = aa ^ bb;
      3'd3: r = aa | bb;
      3'd4: r = aa + m - 1;
      3'd5: begin r = aa + bb; o = (r >= m); end
      3'd6: begin r = aa + m - bb; o = (aa < bb); end
      default: r = aa + 1;
    endcase
    d = r[W-1:0];
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (m_release) begin
      m_release = 1'b0;
      m_free    = 1'b1;
      m_last    = m_last_nxt;
    end
  end

  // Arbitration model: decides who must be granted and queues the expected result.
  always @(negedge clk) begin
    bit   e0, e1, g;
    exp_t e;
    #1;
    if (rst_n) begin
      check("busy", busy, !m_free);
      e0 = 1'b0; e1 = 1'b0; g = 1'b0;
      if (m_free && (v0 || v1)) begin
        g  = (v0 && v1) ? !m_last : v1;
        e0 = !g;
        e1 = g;
      end
      check("req0_ready", r0, e0);
      check("req1_ready", r1, e1);
      if (e0 || e1) begin
        e.id = g;
        e.acc_cyc = cyc;
        if (g) ref_alu(op1, a1, b1, e.data, e.ovf);
        else   ref_alu(op0, a0, b0, e.data, e.ovf);
        sbq.push_back(e);
        grant_log.push_back(g);
        m_free = 1'b0;
        m_acc++;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t got;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (rv && sbq.size() == 0) begin
        check("spurious_rsp", rv, 1'b0);
      end else if (rv) begin
        if (!prev_vld) check("latency", cyc - sbq[0].acc_cyc, 2);
        check("rsp_id", rid, sbq[0].id);
        check("rsp_data", rdata, sbq[0].data);
        check("rsp_ovf", rovf, sbq[0].ovf);
        if (rsp_rdy) begin
          got.id = rid; got.data = rdata; got.ovf = rovf; got.acc_cyc = cyc;
          rsp_log.push_back(got);
          m_last_nxt = sbq[0].id;
          m_release  = 1'b1;
          void'(sbq.pop_front());
        end
      end
      prev_vld = rv;
    end
  end

  task automatic wait_accept();
    int t0 = m_acc;
    bit to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (m_acc != t0) begin to = 1'b0; break; end
    end
    check("accept_timeout", to, 1'b0);
  endtask

  task automatic wait_idle();
    bit to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (m_free && sbq.size() == 0) begin to = 1'b0; break; end
    end
    check("idle_timeout", to, 1'b0);
  endtask

  task automatic send(input bit who, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    if (who) begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else     begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    wait_accept();
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      2: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    // Reset state, with both requests pending to show readies are held low.
    v0 = 1'b1; v1 = 1'b1; op0 = 3'b111; op1 = 3'b111; a0 = 32'h10; a1 = 32'h20;
    #3;
    check("rst_ready0", r0, 0); check("rst_ready1", r1, 0);
    check("rst_valid", rv, 0); check("rst_id", rid, 0);
    check("rst_data", rdata, 0); check("rst_ovf", rovf, 0); check("rst_busy", busy, 0);
    rsp_rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Three back-to-back tie rounds: grants 0,1,0.
    grant_log.delete();
    repeat (3) wait_accept();
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();
    check("rr_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check("rr_grant0", grant_log[0], 0);
      check("rr_grant1", grant_log[1], 1);
      check("rr_grant2", grant_log[2], 0);
    end

    // Simple add and the wrap/borrow corners.
    send(1'b0, 3'b101, 32'h5, 32'h3);
    wait_idle();
    check("add_data", rsp_log[$].data, 32'h8); check("add_id", rsp_log[$].id, 0); check("add_ovf", rsp_log[$].ovf, 0);
    send(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h1);
    wait_idle();
    check("add_wrap_data", rsp_log[$].data, 32'h0); check("add_wrap_ovf", rsp_log[$].ovf, 1);
    send(1'b1, 3'b110, 32'h0, 32'h1);
    wait_idle();
    check("sub_wrap_data", rsp_log[$].data, 32'hFFFF_FFFF); check("sub_wrap_ovf", rsp_log[$].ovf, 1);
    check("sub_wrap_id", rsp_log[$].id, 1);
    send(1'b0, 3'b000, 32'h1, 32'h0);
    wait_idle();
    check("neg_data", rsp_log[$].data, 32'hFFFF_FFFF); check("neg_ovf", rsp_log[$].ovf, 0);

    // Response backpressure: held for 5 cycles with both requesters waiting.
    rsp_rdy = 1'b0;
    send(1'b0, 3'b110, 32'h1234, 32'h99);
    v0 = 1'b1; v1 = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (rv) begin to = 1'b0; break; end
    end
    check("rsp_timeout", to, 1'b0);
    repeat (5) begin
      @(negedge clk); #2;
      check("hold_busy", busy, 1); check("hold_valid", rv, 1);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk); #2;
    check("idle_after_release", busy, 0);
    wait_idle();

    // Reset while the operation sits in EXEC: no response, req0 wins the next tie.
    send(1'b1, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; op0 = 3'b010; op1 = 3'b011;
    #1;
    check("mid_rst_ready0", r0, 0); check("mid_rst_ready1", r1, 0);
    check("mid_rst_valid", rv, 0); check("mid_rst_id", rid, 0);
    check("mid_rst_data", rdata, 0); check("mid_rst_ovf", rovf, 0); check("mid_rst_busy", busy, 0);
    sbq.delete(); m_free = 1'b1; m_last = 1'b1; m_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("tie_after_reset_r0", r0, 1); check("tie_after_reset_r1", r1, 0);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

`ifdef ALU_SHARE_ARB_OVF_STICKY_EN
    ovf_clr = 2'b11;
    @(posedge clk); #1;
    ovf_clr = 2'b00;
    send(1'b1, 3'b101, 32'hFFFF_FFFF, 32'h1);
    wait_idle();
    check("sticky_set", sticky, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check("sticky_hold", sticky, 2'b10);
    ovf_clr = 2'b10;
    @(posedge clk); #1;
    ovf_clr = 2'b00;
    check("sticky_clr", sticky, 2'b00);
`endif

    // Randomized traffic: valids toggle (including drops before handshake), operands change every cycle.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      v0 = ($urandom_range(0, 1) == 1); v1 = ($urandom_range(0, 1) == 1);
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = rnd_val(); b0 = rnd_val(); a1 = rnd_val(); b1 = rnd_val();
      rsp_rdy = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; rsp_rdy = 1'b1;
    wait_idle();
    check("queue_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
